// File: rtl/vga_layer_compositor_pkg.sv
// rtl/vga_layer_compositor_pkg.sv - shared colours, layer/mode enums and heart geometry
package vga_layer_compositor_pkg;

    typedef enum logic [1:0] {
        CLS_BLACK   = 2'd0,
        CLS_WHITE   = 2'd1,
        CLS_CREEPER = 2'd2,
        CLS_ZOMBIE  = 2'd3
    } obstacle_class_e;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_PLAY   = 2'd1,
        MODE_OVER   = 2'd2,
        MODE_PAUSED = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        LAYER_BG,
        LAYER_TRAIL,
        LAYER_OBS,
        LAYER_PLAYER,
        LAYER_HEART,
        LAYER_OFF
    } layer_e;

    localparam logic [11:0] COL_HEART   = 12'hF22;
    localparam logic [11:0] COL_PLAYER  = 12'hFA0;
    localparam logic [11:0] COL_BLACK   = 12'h111;
    localparam logic [11:0] COL_WHITE   = 12'hEEE;
    localparam logic [11:0] COL_CREEPER = 12'h2C2;
    localparam logic [11:0] COL_ZOMBIE  = 12'h3A6;
    localparam logic [11:0] COL_BG      = 12'h135;
    localparam logic [11:0] COL_OFF     = 12'h000;

    localparam int N_HEART     = 7;
    localparam int HEART_X0    = 8;
    localparam int HEART_PITCH = 20;
    localparam int HEART_Y0    = 8;
    localparam int HEART_SIZE  = 16;

    function automatic logic [11:0] class_colour(input obstacle_class_e cls);
        case (cls)
            CLS_BLACK:   return COL_BLACK;
            CLS_WHITE:   return COL_WHITE;
            CLS_CREEPER: return COL_CREEPER;
            default:     return COL_ZOMBIE;
        endcase
    endfunction

endpackage

// File: rtl/vga_layer_compositor_rect_hit.sv
// rtl/vga_layer_compositor_rect_hit.sv - half-open rectangle membership test
module vga_layer_compositor_rect_hit (
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic [9:0]  left,
    input  logic [8:0]  top,
    input  logic [10:0] w_px,
    input  logic [9:0]  h_px,
    output logic        hit
);

    // One extra bit on the far edges so a box near the right/bottom limit never wraps.
    logic [10:0] x_end;
    logic [9:0]  y_end;

    assign x_end = {1'b0, left} + w_px;
    assign y_end = {1'b0, top} + h_px;
    assign hit   = (x >= left) && ({1'b0, x} < x_end) && (y >= top) && ({1'b0, y} < y_end);

endmodule

// File: rtl/vga_layer_compositor.sv
// rtl/vga_layer_compositor.sv - 3-stage layered pixel renderer with frame-shadowed object tables
module vga_layer_compositor
    import vga_layer_compositor_pkg::*;
#(
    parameter int N_OBS       = 10,
    parameter int N_TRAIL     = 41,
    parameter int UNIT_SIZE   = 30,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int PLAYER_X    = 150,
    parameter int PLAYER_SIZE = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic [9:0]            pix_x,
    input  logic [8:0]            pix_y,
    input  logic [1:0]            gamemode,
    input  logic [8:0]            player_y,
    input  logic [2:0]            heart,
    input  logic [N_OBS*2-1:0]    obstacle_class,
    input  logic [N_OBS*10-1:0]   obstacle_x_game_left,
    input  logic [N_OBS*3-1:0]    width,
    input  logic [N_OBS*9-1:0]    obstacle_y_game_up,
    input  logic [N_OBS*4-1:0]    height,
    input  logic [N_TRAIL*10-1:0] trail_x,
    input  logic [N_TRAIL*9-1:0]  trail_y,
    input  logic [N_TRAIL*4-1:0]  trail_life,
    output logic [11:0]           rgb,
    output logic                  rgb_valid,
    output logic [9:0]            out_x,
    output logic [8:0]            out_y,
    output logic                  collision
);

    localparam logic [10:0] H_LIM = 11'(H_RES);
    localparam logic [9:0]  V_LIM = 10'(V_RES);

    logic [N_OBS*2-1:0]    sh_cls_q, sh_cls_d;
    logic [N_OBS*10-1:0]   sh_ox_q, sh_ox_d;
    logic [N_OBS*3-1:0]    sh_w_q, sh_w_d;
    logic [N_OBS*9-1:0]    sh_oy_q, sh_oy_d;
    logic [N_OBS*4-1:0]    sh_h_q, sh_h_d;
    logic [N_TRAIL*10-1:0] sh_tx_q, sh_tx_d;
    logic [N_TRAIL*9-1:0]  sh_ty_q, sh_ty_d;
    logic [N_TRAIL*4-1:0]  sh_life_q, sh_life_d;
    logic [8:0]            sh_py_q, sh_py_d;
    logic [2:0]            sh_heart_q, sh_heart_d;
    mode_e                 sh_mode_q, sh_mode_d;

    logic                  s1_valid_q, s1_valid_d, s1_player_q, s1_player_d, s1_heart_q, s1_heart_d;
    logic [9:0]            s1_x_q, s1_x_d;
    logic [8:0]            s1_y_q, s1_y_d;
    mode_e                 s1_mode_q, s1_mode_d;
    logic [N_OBS-1:0]      s1_obs_hit_q, s1_obs_hit_d;
    logic [N_TRAIL-1:0]    s1_trail_hit_q, s1_trail_hit_d;
    logic [N_OBS*2-1:0]    s1_cls_q, s1_cls_d;
    logic [N_TRAIL*4-1:0]  s1_life_q, s1_life_d;

    logic                  s2_valid_q, s2_valid_d, s2_coll_q, s2_coll_d;
    logic [9:0]            s2_x_q, s2_x_d;
    logic [8:0]            s2_y_q, s2_y_d;
    mode_e                 s2_mode_q, s2_mode_d;
    layer_e                s2_layer_q, s2_layer_d;
    obstacle_class_e       s2_cls_q, s2_cls_d;
    logic [3:0]            s2_life_q, s2_life_d;

    logic [11:0]           rgb_q, rgb_d;
    logic                  rgb_valid_q, rgb_valid_d, acc_q, acc_d, collision_q, collision_d;
    logic [9:0]            out_x_q, out_x_d;
    logic [8:0]            out_y_q, out_y_d;

    logic [N_OBS-1:0]      obs_hit;
    logic [N_TRAIL-1:0]    trail_hit;
    logic [N_HEART-1:0]    heart_hit;
    logic                  player_hit, obs_any, trail_any, offscreen, s2_coll_live;
    logic [11:0]           colour;

    for (genvar i = 0; i < N_OBS; i++) begin : g_obs
        vga_layer_compositor_rect_hit u_hit (
            .x(pix_x), .y(pix_y), .left(sh_ox_q[i*10+:10]), .top(sh_oy_q[i*9+:9]),
            .w_px(11'(sh_w_q[i*3+:3] * UNIT_SIZE)), .h_px(10'(sh_h_q[i*4+:4] * UNIT_SIZE)),
            .hit(obs_hit[i])
        );
    end

    for (genvar j = 0; j < N_TRAIL; j++) begin : g_trail
        logic raw;
        vga_layer_compositor_rect_hit u_hit (
            .x(pix_x), .y(pix_y), .left(sh_tx_q[j*10+:10]), .top(sh_ty_q[j*9+:9]),
            .w_px(11'd2), .h_px(10'd2), .hit(raw)
        );
        assign trail_hit[j] = raw && (sh_life_q[j*4+:4] != 4'd0);
    end

    for (genvar k = 0; k < N_HEART; k++) begin : g_heart
        logic raw;
        vga_layer_compositor_rect_hit u_hit (
            .x(pix_x), .y(pix_y), .left(10'(HEART_X0 + HEART_PITCH * k)), .top(9'(HEART_Y0)),
            .w_px(11'(HEART_SIZE)), .h_px(10'(HEART_SIZE)), .hit(raw)
        );
        assign heart_hit[k] = raw && (3'(k) < sh_heart_q);
    end

    vga_layer_compositor_rect_hit u_player_hit (
        .x(pix_x), .y(pix_y), .left(10'(PLAYER_X)), .top(sh_py_q),
        .w_px(11'(PLAYER_SIZE)), .h_px(10'(PLAYER_SIZE)), .hit(player_hit)
    );

    always_comb begin
        {sh_cls_d, sh_ox_d, sh_w_d, sh_oy_d, sh_h_d} = {sh_cls_q, sh_ox_q, sh_w_q, sh_oy_q, sh_h_q};
        {sh_tx_d, sh_ty_d, sh_life_d, sh_py_d, sh_heart_d} = {sh_tx_q, sh_ty_q, sh_life_q, sh_py_q, sh_heart_q};
        sh_mode_d = sh_mode_q;
        if (frame_start) begin
            {sh_cls_d, sh_ox_d, sh_w_d, sh_oy_d, sh_h_d} =
                {obstacle_class, obstacle_x_game_left, width, obstacle_y_game_up, height};
            {sh_tx_d, sh_ty_d, sh_life_d, sh_py_d, sh_heart_d} = {trail_x, trail_y, trail_life, player_y, heart};
            sh_mode_d = mode_e'(gamemode);
        end
        // Per-pixel copies of the class/life tables keep a pixel consistent if the shadow reloads behind it.
        s1_valid_d     = pix_valid;
        s1_x_d         = pix_x;
        s1_y_d         = pix_y;
        s1_mode_d      = sh_mode_q;
        s1_obs_hit_d   = obs_hit;
        s1_trail_hit_d = trail_hit;
        s1_player_d    = player_hit;
        s1_heart_d     = |heart_hit;
        s1_cls_d       = sh_cls_q;
        s1_life_d      = sh_life_q;
    end

    always_comb begin
        obs_any   = 1'b0;
        trail_any = 1'b0;
        s2_cls_d  = CLS_BLACK;
        s2_life_d = 4'd0;
        for (int i = N_OBS - 1; i >= 0; i--) begin
            if (s1_obs_hit_q[i]) begin
                obs_any  = 1'b1;
                s2_cls_d = obstacle_class_e'(s1_cls_q[i*2+:2]);
            end
        end
        for (int j = N_TRAIL - 1; j >= 0; j--) begin
            if (s1_trail_hit_q[j]) begin
                trail_any = 1'b1;
                s2_life_d = s1_life_q[j*4+:4];
            end
        end
        offscreen = ({1'b0, s1_x_q} >= H_LIM) || ({1'b0, s1_y_q} >= V_LIM);
        if (offscreen)                   s2_layer_d = LAYER_OFF;
        else if (s1_mode_q == MODE_IDLE) s2_layer_d = s1_player_q ? LAYER_PLAYER : LAYER_BG;
        else if (s1_heart_q)             s2_layer_d = LAYER_HEART;
        else if (s1_player_q)            s2_layer_d = LAYER_PLAYER;
        else if (obs_any)                s2_layer_d = LAYER_OBS;
        else if (trail_any)              s2_layer_d = LAYER_TRAIL;
        else                             s2_layer_d = LAYER_BG;
        s2_valid_d = s1_valid_q;
        s2_x_d     = s1_x_q;
        s2_y_d     = s1_y_q;
        s2_mode_d  = s1_mode_q;
        s2_coll_d  = s1_player_q && obs_any;
    end

    always_comb begin
        case (s2_layer_q)
            LAYER_HEART:  colour = COL_HEART;
            LAYER_PLAYER: colour = COL_PLAYER;
            LAYER_OBS:    colour = class_colour(s2_cls_q);
            LAYER_TRAIL:  colour = {s2_life_q, s2_life_q, 4'hF};
            LAYER_OFF:    colour = COL_OFF;
            default:      colour = COL_BG;
        endcase
        if (s2_layer_q != LAYER_OFF) begin
            if (s2_mode_q == MODE_OVER)
                colour[11:8] = 4'hF;
            else if (s2_mode_q == MODE_PAUSED)
                colour = {1'b0, colour[11:9], 1'b0, colour[7:5], 1'b0, colour[3:1]};
        end
        rgb_valid_d  = s2_valid_q;
        rgb_d        = s2_valid_q ? colour : rgb_q;
        out_x_d      = s2_valid_q ? s2_x_q : out_x_q;
        out_y_d      = s2_valid_q ? s2_y_q : out_y_q;
        // The pixel sitting in S2 at frame_start still belongs to the frame being closed.
        s2_coll_live = s2_valid_q && s2_coll_q;
        acc_d        = frame_start ? 1'b0 : (acc_q | s2_coll_live);
        collision_d  = frame_start ? (acc_q | s2_coll_live) : collision_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {sh_cls_q, sh_ox_q, sh_w_q, sh_oy_q, sh_h_q} <= '0;
            {sh_tx_q, sh_ty_q, sh_life_q, sh_py_q, sh_heart_q} <= '0;
            sh_mode_q      <= MODE_IDLE;
            s1_valid_q     <= 1'b0;
            s1_x_q         <= '0;
            s1_y_q         <= '0;
            s1_mode_q      <= MODE_IDLE;
            s1_obs_hit_q   <= '0;
            s1_trail_hit_q <= '0;
            s1_player_q    <= 1'b0;
            s1_heart_q     <= 1'b0;
            s1_cls_q       <= '0;
            s1_life_q      <= '0;
            s2_valid_q     <= 1'b0;
            s2_x_q         <= '0;
            s2_y_q         <= '0;
            s2_mode_q      <= MODE_IDLE;
            s2_layer_q     <= LAYER_BG;
            s2_cls_q       <= CLS_BLACK;
            s2_life_q      <= '0;
            s2_coll_q      <= 1'b0;
            rgb_q          <= '0;
            rgb_valid_q    <= 1'b0;
            out_x_q        <= '0;
            out_y_q        <= '0;
            acc_q          <= 1'b0;
            collision_q    <= 1'b0;
        end else begin
            {sh_cls_q, sh_ox_q, sh_w_q, sh_oy_q, sh_h_q} <= {sh_cls_d, sh_ox_d, sh_w_d, sh_oy_d, sh_h_d};
            {sh_tx_q, sh_ty_q, sh_life_q, sh_py_q, sh_heart_q} <= {sh_tx_d, sh_ty_d, sh_life_d, sh_py_d, sh_heart_d};
            sh_mode_q      <= sh_mode_d;
            s1_valid_q     <= s1_valid_d;
            s1_x_q         <= s1_x_d;
            s1_y_q         <= s1_y_d;
            s1_mode_q      <= s1_mode_d;
            s1_obs_hit_q   <= s1_obs_hit_d;
            s1_trail_hit_q <= s1_trail_hit_d;
            s1_player_q    <= s1_player_d;
            s1_heart_q     <= s1_heart_d;
            s1_cls_q       <= s1_cls_d;
            s1_life_q      <= s1_life_d;
            s2_valid_q     <= s2_valid_d;
            s2_x_q         <= s2_x_d;
            s2_y_q         <= s2_y_d;
            s2_mode_q      <= s2_mode_d;
            s2_layer_q     <= s2_layer_d;
            s2_cls_q       <= s2_cls_d;
            s2_life_q      <= s2_life_d;
            s2_coll_q      <= s2_coll_d;
            rgb_q          <= rgb_d;
            rgb_valid_q    <= rgb_valid_d;
            out_x_q        <= out_x_d;
            out_y_q        <= out_y_d;
            acc_q          <= acc_d;
            collision_q    <= collision_d;
        end
    end

    assign rgb       = rgb_q;
    assign rgb_valid = rgb_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// tb/tb_vga_layer_compositor.sv - directed and random bench against a behavioural scene model
module tb_vga_layer_compositor;

    localparam int N_OBS   = 10;
    localparam int N_TRAIL = 41;

    logic                  clk = 1'b0;
    logic                  rst, frame_start, pix_valid;
    logic [9:0]            pix_x;
    logic [8:0]            pix_y;
    logic [1:0]            gamemode;
    logic [8:0]            player_y;
    logic [2:0]            heart;
    logic [N_OBS*2-1:0]    obstacle_class;
    logic [N_OBS*10-1:0]   obstacle_x_game_left;
    logic [N_OBS*3-1:0]    width;
    logic [N_OBS*9-1:0]    obstacle_y_game_up;
    logic [N_OBS*4-1:0]    height;
    logic [N_TRAIL*10-1:0] trail_x;
    logic [N_TRAIL*9-1:0]  trail_y;
    logic [N_TRAIL*4-1:0]  trail_life;
    logic [11:0]           rgb;
    logic                  rgb_valid, collision;
    logic [9:0]            out_x;
    logic [8:0]            out_y;

    int in_cls[N_OBS], in_ox[N_OBS], in_w[N_OBS], in_oy[N_OBS], in_h[N_OBS];
    int in_tx[N_TRAIL], in_ty[N_TRAIL], in_life[N_TRAIL];
    int in_py, in_heart, in_mode;
    int sh_cls[N_OBS], sh_ox[N_OBS], sh_w[N_OBS], sh_oy[N_OBS], sh_h[N_OBS];
    int sh_tx[N_TRAIL], sh_ty[N_TRAIL], sh_life[N_TRAIL];
    int sh_py, sh_heart, sh_mode;

    typedef struct {
        bit          valid;
        logic [11:0] rgb;
        int          x;
        int          y;
    } exp_t;

    exp_t        pipe[$];
    logic [11:0] last_rgb;
    int          last_x, last_y;
    bit          acc, coll_exp;
    int          vectors = 0;
    int          miscompares = 0;

    vga_layer_compositor dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .gamemode(gamemode), .player_y(player_y), .heart(heart),
        .obstacle_class(obstacle_class), .obstacle_x_game_left(obstacle_x_game_left),
        .width(width), .obstacle_y_game_up(obstacle_y_game_up), .height(height),
        .trail_x(trail_x), .trail_y(trail_y), .trail_life(trail_life),
        .rgb(rgb), .rgb_valid(rgb_valid), .out_x(out_x), .out_y(out_y), .collision(collision)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N_OBS; i++) begin
            obstacle_class[i*2+:2]        = 2'(in_cls[i]);
            obstacle_x_game_left[i*10+:10] = 10'(in_ox[i]);
            width[i*3+:3]                 = 3'(in_w[i]);
            obstacle_y_game_up[i*9+:9]    = 9'(in_oy[i]);
            height[i*4+:4]                = 4'(in_h[i]);
        end
        for (int j = 0; j < N_TRAIL; j++) begin
            trail_x[j*10+:10]  = 10'(in_tx[j]);
            trail_y[j*9+:9]    = 9'(in_ty[j]);
            trail_life[j*4+:4] = 4'(in_life[j]);
        end
        gamemode = 2'(in_mode);
        player_y = 9'(in_py);
        heart    = 3'(in_heart);
    end

    // Scene evaluation straight from the layer rules: containment tests, first match wins.
    function automatic void ref_pixel(input int x, input int y, output logic [11:0] c, output bit coll);
        bit pl, ob, tr, ht;
        int cls, life, col, r, g, b;
        ob = 0; tr = 0; ht = 0; cls = 0; life = 0;
        pl = x >= 150 && x < 170 && y >= sh_py && y < sh_py + 20;
        for (int i = 0; i < N_OBS; i++)
            if (!ob && x >= sh_ox[i] && x < sh_ox[i] + sh_w[i] * 30 && y >= sh_oy[i] && y < sh_oy[i] + sh_h[i] * 30) begin
                ob = 1; cls = sh_cls[i];
            end
        for (int j = 0; j < N_TRAIL; j++)
            if (!tr && sh_life[j] != 0 && x >= sh_tx[j] && x < sh_tx[j] + 2 && y >= sh_ty[j] && y < sh_ty[j] + 2) begin
                tr = 1; life = sh_life[j];
            end
        for (int k = 0; k < sh_heart; k++)
            if (x >= 8 + 20 * k && x < 24 + 20 * k && y >= 8 && y < 24) ht = 1;
        coll = pl && ob;
        if (x >= 640 || y >= 480) col = 0;
        else begin
            if (sh_mode == 0) col = pl ? 'hFA0 : 'h135;
            else if (ht)      col = 'hF22;
            else if (pl)      col = 'hFA0;
            else if (ob)      col = (cls == 0) ? 'h111 : (cls == 1) ? 'hEEE : (cls == 2) ? 'h2C2 : 'h3A6;
            else if (tr)      col = life * 256 + life * 16 + 15;
            else              col = 'h135;
            r = col / 256; g = (col / 16) % 16; b = col % 16;
            if (sh_mode == 2) r = 15;
            else if (sh_mode == 3) begin r = r / 2; g = g / 2; b = b / 2; end
            col = r * 256 + g * 16 + b;
        end
        c = 12'(col);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic latch_shadow();
        sh_cls = in_cls; sh_ox = in_ox; sh_w = in_w; sh_oy = in_oy; sh_h = in_h;
        sh_tx = in_tx; sh_ty = in_ty; sh_life = in_life;
        sh_py = in_py; sh_heart = in_heart; sh_mode = in_mode;
    endtask

    task automatic model_reset();
        exp_t e;
        e.valid = 0; e.rgb = '0; e.x = 0; e.y = 0;
        foreach (sh_cls[i]) begin sh_cls[i] = 0; sh_ox[i] = 0; sh_w[i] = 0; sh_oy[i] = 0; sh_h[i] = 0; end
        foreach (sh_tx[j]) begin sh_tx[j] = 0; sh_ty[j] = 0; sh_life[j] = 0; end
        sh_py = 0; sh_heart = 0; sh_mode = 0;
        pipe.delete();
        pipe.push_back(e);
        pipe.push_back(e);
        last_rgb = '0; last_x = 0; last_y = 0;
        acc = 0; coll_exp = 0;
    endtask

    // One clock: predict the presented pixel, advance, then check what leaves the pipe now.
    task automatic tick();
        exp_t        e;
        logic [11:0] c;
        bit          co;
        c = '0; co = 0;
        e.valid = pix_valid; e.x = int'(pix_x); e.y = int'(pix_y);
        if (pix_valid) ref_pixel(int'(pix_x), int'(pix_y), c, co);
        e.rgb = c;
        pipe.push_back(e);
        @(posedge clk);
        if (frame_start) begin coll_exp = acc; acc = 0; latch_shadow(); end
        acc = acc | co;
        #1;
        e = pipe.pop_front();
        chk("rgb_valid", 32'(rgb_valid), 32'(e.valid));
        if (e.valid) begin last_rgb = e.rgb; last_x = e.x; last_y = e.y; end
        chk("rgb", 32'(rgb), 32'(last_rgb));
        chk("out_x", 32'(out_x), 32'(last_x));
        chk("out_y", 32'(out_y), 32'(last_y));
        chk("collision", 32'(collision), 32'(coll_exp));
        pix_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        pix_valid = 1'b1; pix_x = 10'(x); pix_y = 9'(y);
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic frame();
        idle(3);
        frame_start = 1'b1;
        tick();
    endtask

    task automatic scan_player_box();
        for (int y = 195; y < 230; y++)
            for (int x = 145; x < 175; x++) pix(x, y);
    endtask

    task automatic random_scene();
        for (int i = 0; i < N_OBS; i++) begin
            in_cls[i] = $urandom_range(0, 3); in_ox[i] = $urandom_range(0, 400); in_w[i] = $urandom_range(0, 7);
            in_oy[i]  = $urandom_range(0, 300); in_h[i] = $urandom_range(0, 15);
        end
        for (int j = 0; j < N_TRAIL; j++) begin
            in_tx[j] = $urandom_range(0, 400); in_ty[j] = $urandom_range(0, 300);
            in_life[j] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : 0;
        end
        in_py = $urandom_range(0, 300); in_heart = $urandom_range(0, 7); in_mode = $urandom_range(0, 3);
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
        in_py = 0; in_heart = 0; in_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rgb", 32'(rgb), 32'h0);
        chk("reset_rgb_valid", 32'(rgb_valid), 32'h0);
        chk("reset_out_x", 32'(out_x), 32'h0);
        chk("reset_out_y", 32'(out_y), 32'h0);
        chk("reset_collision", 32'(collision), 32'h0);
        rst = 1'b0;
        model_reset();

        pix(0, 0); pix(155, 5); pix(639, 479); idle(3);

        in_cls[0] = 2; in_ox[0] = 100; in_oy[0] = 80; in_w[0] = 1; in_h[0] = 2; in_py = 300; in_mode = 1;
        frame();
        pix(129, 139); idle(3); pix(130, 139); pix(100, 80); pix(640, 0); pix(0, 480); idle(3);

        in_cls[0] = 1; in_ox[0] = 200; in_oy[0] = 200; in_w[0] = 1; in_h[0] = 1;
        in_cls[1] = 3; in_ox[1] = 190; in_oy[1] = 190; in_w[1] = 2; in_h[1] = 2; in_heart = 4;
        pix_valid = 1'b1; pix_x = 10'd129; pix_y = 9'd139;
        idle(3); frame_start = 1'b1; pix_valid = 1'b1; pix_x = 10'd129; pix_y = 9'd139; tick();
        pix(200, 200); pix(230, 240); pix(70, 10); pix(90, 10); idle(3);

        in_w[0] = 0; in_w[1] = 0; in_heart = 0;
        in_life[0] = 9; in_tx[0] = 140; in_ty[0] = 110; in_mode = 3;
        frame();
        pix(141, 111); pix(142, 111); idle(2);
        in_mode = 2;
        frame();
        pix(141, 111); idle(2);
        in_life[0] = 0; in_mode = 1; in_heart = 7;
        pix(141, 111); pix(10, 10); idle(3);
        frame();
        pix(141, 111); pix(10, 10); idle(3);

        in_heart = 0; in_py = 200;
        in_cls[0] = 0; in_ox[0] = 160; in_oy[0] = 210; in_w[0] = 1; in_h[0] = 1;
        frame();
        scan_player_box();
        frame();
        chk("collision_set", 32'(collision), 32'h1);

        pix(10, 10); pix(11, 10);
        rst = 1'b1;
        #1;
        chk("midreset_rgb", 32'(rgb), 32'h0);
        chk("midreset_rgb_valid", 32'(rgb_valid), 32'h0);
        chk("midreset_collision", 32'(collision), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        pix(155, 5); idle(3);

        frame();
        scan_player_box();
        in_w[0] = 0;
        frame();
        chk("collision_again", 32'(collision), 32'h1);
        scan_player_box();
        frame();
        chk("collision_clear", 32'(collision), 32'h0);

        repeat (4) begin
            random_scene();
            frame();
            repeat (400) begin
                if ($urandom_range(0, 4) == 0) idle(1);
                else if ($urandom_range(0, 9) == 0) pix($urandom_range(0, 700), $urandom_range(0, 511));
                else pix($urandom_range(0, 420), $urandom_range(0, 330));
            end
            idle(3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
